vram_port_arbiter: RTL and testbench

Shares the single read/write port A of video_memory between up to NUM_REQ command engines: the graphics instruction engine, the blitter/fill engine, and the CPU direct-access path. Round-robin arbitration, one access per cycle, optional burst lock. A per-beat tag pipeline returns read data to the requester that issued it. Sits between the engines and video_memory port A; port B (display scan-out) is untouched.

---
 rtl/vram_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing video_memory port A between command engines, with burst lock
// and a read-tag pipeline. Define VRAM_ARB_PRIO_EN to give requester 0 strict preemptive priority.
module vram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                      video_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   burst_q, burst_d, burst_inc;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         win;
  logic [1:0]         scan_idx;
  logic               accept;
  logic               preempt;
  logic [NUM_REQ-1:0] new_tag;
  logic [NUM_REQ-1:0] tag_q [RD_LATENCY+1];
  logic               pipe_any;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               mem_we_q;

  // Winner selection: the lock owner only, otherwise the first valid requester after the pointer.
  always_comb begin
    grant    = '0;
    win      = ptr_q;
    preempt  = 1'b0;
    scan_idx = '0;
    if (state_q == LOCKED) begin
      if (req_valid[owner_q]) begin
        grant[owner_q] = 1'b1;
        win            = owner_q;
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        scan_idx = 2'((int'(ptr_q) + k) % NUM_REQ);
        if (req_valid[scan_idx]) begin
          grant           = '0;
          grant[scan_idx] = 1'b1;
          win             = scan_idx;
        end
      end
    end
`ifdef VRAM_ARB_PRIO_EN
    if (req_valid[0]) begin
      grant    = '0;
      grant[0] = 1'b1;
      win      = '0;
      preempt  = 1'b1;
    end
`endif
  end

  assign accept    = |grant;
  assign burst_inc = burst_q + CNT_W'(1);

  // A preemptive grant leaves the pointer, lock state and burst count untouched.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    grant_id_d = grant_id_q;
    if (accept) begin
      grant_id_d = win;
    end
    if (accept && !preempt) begin
      if (state_q == ARB) begin
        ptr_d = win;
        if (req_lock[win] && (MAX_BURST > 1)) begin
          state_d = LOCKED;
          owner_d = win;
          burst_d = CNT_W'(1);
        end
      end else begin
        burst_d = burst_inc;
        if (!req_lock[owner_q] || (burst_inc == CNT_W'(MAX_BURST))) begin
          state_d = ARB;
          burst_d = '0;
        end
      end
    end else if (!preempt && (state_q == LOCKED) && !req_lock[owner_q]) begin
      state_d = ARB;
      burst_d = '0;
    end
  end

  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      ptr_q      <= 2'(NUM_REQ - 1);
      owner_q    <= '0;
      burst_q    <= '0;
      grant_id_q <= 2'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_we_q <= accept && req_we[win];
      if (accept) begin
        mem_addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
        mem_wdata_q <= req_wdata[win*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot read tags ride alongside the memory latency so data returns to its issuer.
  assign new_tag = (accept && !req_we[win]) ? grant : '0;

  always_ff @(posedge video_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      pipe_any = pipe_any | (|tag_q[i]);
    end
  end

  assign req_ready = grant;
  assign rsp_valid = tag_q[RD_LATENCY];
  // mem_rdata already comes straight off the BRAM output register.
  assign rsp_rdata = (|tag_q[RD_LATENCY]) ? mem_rdata : '0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign grant_id  = grant_id_q;
  assign busy      = pipe_any || (state_q == LOCKED);

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter with a read-response scoreboard
// and a behavioural BRAM on port A.
module tb_vram_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 17;
  localparam int DW = 8;

  logic            video_clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we, busy;
  logic [1:0]      grant_id;

  typedef struct {
    int            cyc;
    logic [NR-1:0] tag;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [AW-1:0] addrs [NR];
  logic [DW-1:0] wdatas [NR];
  logic [DW-1:0] ram [logic [AW-1:0]];
  logic [DW-1:0] model [logic [AW-1:0]];

  vram_port_arbiter dut (
    .video_clk(video_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 video_clk = ~video_clk;

  always @(posedge video_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Read-first BRAM with one registered output stage.
  always @(posedge video_clk) begin
    mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : initVal(mem_addr);
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  always @(negedge video_clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      checks++;
      assert (rsp_valid === sb[0].tag) else begin
        failures++;
        $error("FAIL rspTag cyc=%0d got=%b exp=%b", cyc, rsp_valid, sb[0].tag);
      end
      checks++;
      assert (rsp_rdata === sb[0].data) else begin
        failures++;
        $error("FAIL rspData cyc=%0d got=%h exp=%h", cyc, rsp_rdata, sb[0].data);
      end
      sb.delete(0);
    end else begin
      checks++;
      assert (rsp_valid === '0) else begin
        failures++;
        $error("FAIL rspIdle cyc=%0d got=%b exp=000", cyc, rsp_valid);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One cycle of stimulus; expected grants drive the scoreboard and the reference memory.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] we,
                               input logic [NR-1:0] lk, input logic [NR-1:0] expReady,
                               input string name);
    @(posedge video_clk);
    #1;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = addrs[i];
      req_wdata[i*DW +: DW] = wdatas[i];
    end
    #1;
    checkOutput(name, 32'(req_ready), 32'(expReady));
    for (int i = 0; i < NR; i++) begin
      if (expReady[i]) begin
        if (we[i]) begin
          model[addrs[i]] = wdatas[i];
        end else begin
          sb.push_back('{cyc: cyc + 2, tag: expReady,
                         data: model.exists(addrs[i]) ? model[addrs[i]] : initVal(addrs[i])});
        end
      end
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "Ready"}, 32'(req_ready), 0);
    checkOutput({name, "Rsp"}, 32'(rsp_valid), 0);
    checkOutput({name, "Rdata"}, 32'(rsp_rdata), 0);
    checkOutput({name, "Addr"}, 32'(mem_addr), 0);
    checkOutput({name, "Wdata"}, 32'(mem_wdata), 0);
    checkOutput({name, "We"}, 32'(mem_we), 0);
    checkOutput({name, "Gid"}, 32'(grant_id), 2);
    checkOutput({name, "Busy"}, 32'(busy), 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    addrs[0]  = 17'h00100;
    addrs[1]  = 17'h1F3A1;
    addrs[2]  = 17'h00200;
    wdatas[0] = 8'h11;
    wdatas[1] = 8'hA5;
    wdatas[2] = 8'h33;
    repeat (2) @(posedge video_clk);
    #2;
    checkReset("rst");
    @(negedge video_clk);
    reset = 1'b0;

`ifdef VRAM_ARB_PRIO_EN
    applyStimulus(3'b100, 3'b000, 3'b100, 3'b100, "pLk1");
    for (int i = 2; i <= 5; i++) applyStimulus(3'b100, 3'b000, 3'b100, 3'b100, "pLkBeat");
    applyStimulus(3'b101, 3'b000, 3'b100, 3'b001, "pPreempt");
    applyStimulus(3'b100, 3'b000, 3'b100, 3'b100, "pResume");
    checkOutput("pGid", 32'(grant_id), 0);
    checkOutput("pBusy", 32'(busy), 1);
    for (int i = 7; i <= 16; i++) applyStimulus(3'b100, 3'b000, 3'b100, 3'b100, "pLkTail");
    applyStimulus(3'b110, 3'b000, 3'b000, 3'b010, "pExit");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "pIdle");
`else
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b111, 3'b000, 3'b000, 3'(1 << (i % 3)), "rr");
      if (i == 1) begin
        checkOutput("rrAddr", 32'(mem_addr), 32'(addrs[0]));
        checkOutput("rrGid", 32'(grant_id), 0);
      end
      checkOutput("rrWe", 32'(mem_we), 0);
    end
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "rrIdle");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "rrIdle");

    addrs[2] = 17'h1F3A1;
    applyStimulus(3'b010, 3'b010, 3'b000, 3'b010, "wr1");
    applyStimulus(3'b100, 3'b000, 3'b000, 3'b100, "rd2");
    checkOutput("wrWe", 32'(mem_we), 1);
    checkOutput("wrAddr", 32'(mem_addr), 32'h1F3A1);
    checkOutput("wrData", 32'(mem_wdata), 32'hA5);
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "wrIdle");
    checkOutput("rdWe", 32'(mem_we), 0);
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "wrIdle");
    addrs[2] = 17'h00200;

    applyStimulus(3'b100, 3'b000, 3'b100, 3'b100, "lkFirst");
    for (int i = 2; i <= 16; i++) begin
      applyStimulus(3'b111, 3'b000, 3'b100, 3'b100, "lkBeat");
      checkOutput("lkBusy", 32'(busy), 1);
    end
    applyStimulus(3'b111, 3'b000, 3'b100, 3'b001, "lkThen0");
    applyStimulus(3'b111, 3'b000, 3'b100, 3'b010, "lkThen1");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "lkIdle");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "lkIdle");

    applyStimulus(3'b010, 3'b000, 3'b010, 3'b010, "stLk");
    applyStimulus(3'b011, 3'b000, 3'b010, 3'b010, "stBeat");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b001, 3'b000, 3'b010, 3'b000, "stStall");
      checkOutput("stBusy", 32'(busy), 1);
    end
    applyStimulus(3'b001, 3'b000, 3'b000, 3'b000, "stRelease");
    checkOutput("stRelBusy", 32'(busy), 1);
    applyStimulus(3'b001, 3'b000, 3'b000, 3'b001, "stAfter");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "stIdle");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "stIdle");

    applyStimulus(3'b110, 3'b000, 3'b000, 3'b010, "mrRd1");
    applyStimulus(3'b110, 3'b000, 3'b000, 3'b100, "mrRd2");
    @(posedge video_clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    sb.delete();
    #1;
    checkReset("mrRst");
    repeat (2) @(posedge video_clk);
    @(negedge video_clk);
    reset = 1'b0;
    applyStimulus(3'b111, 3'b000, 3'b000, 3'b001, "mrPost");
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, "mrIdle");
`endif

    repeat (4) @(posedge video_clk);
    #2;
    checkOutput("sbEmpty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
